// File: rtl/axi4_lite_rect_fill.sv
// axi4_lite_rect_fill
//   AXI4-Lite controlled rectangle-fill engine. The CPU programs POS, SIZE and
//   COLOR, then writes LAUNCH to queue a snapshot of them. The engine pops
//   queued commands, clips them to H_RES x V_RES and writes one pixel per
//   clock into a write-only framebuffer BRAM port.
//
// Ports
//   s_axi_ctrl_aclk / s_axi_ctrl_aresetn : clock, asynchronous active-low reset
//   s_axi_ctrl_ar* / r*                  : AXI4-Lite read address / read data
//   s_axi_ctrl_aw* / w* / b*             : AXI4-Lite write address / data / response
//   fbuf_en_wr, fbuf_wrea                : BRAM enable / write enable (high while filling)
//   fbuf_addr, fbuf_data                 : pixel address (y*H_RES + x) and pixel value
//   fbuf_rst_req_n                       : one-cycle active-low framebuffer clear request
//
// Register map (byte offsets, addr[4:2] decoded)
//   0x00 W CTRL  [0] ABORT, [1] CLEAR     R STATUS [0] BUSY [1] FULL [2] EMPTY [3] OVF [15:8] level
//   0x04 POS {y0,x0}   0x08 SIZE {h,w}   0x0C COLOR   0x10 W LAUNCH (reads 0)
//   other offsets answer SLVERR
module axi4_lite_rect_fill #(
    parameter int AXI_ADDRESS_WIDTH = 32,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int FBUF_ADDR_WIDTH   = 19,
    parameter int FBUF_DATA_WIDTH   = 8,
    parameter int H_RES             = 640,
    parameter int V_RES             = 480,
    parameter int CMD_FIFO_DEPTH    = 4
) (
    input  logic                         s_axi_ctrl_aclk,
    input  logic                         s_axi_ctrl_aresetn,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_araddr,
    input  logic                         s_axi_ctrl_arvalid,
    output logic                         s_axi_ctrl_arready,
    output logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_rdata,
    output logic [1:0]                   s_axi_ctrl_rresp,
    output logic                         s_axi_ctrl_rvalid,
    input  logic                         s_axi_ctrl_rready,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_ctrl_awaddr,
    input  logic                         s_axi_ctrl_awvalid,
    output logic                         s_axi_ctrl_awready,
    input  logic [AXI_DATA_WIDTH-1:0]    s_axi_ctrl_wdata,
    input  logic                         s_axi_ctrl_wvalid,
    output logic                         s_axi_ctrl_wready,
    output logic [1:0]                   s_axi_ctrl_bresp,
    output logic                         s_axi_ctrl_bvalid,
    input  logic                         s_axi_ctrl_bready,
    output logic                         fbuf_en_wr,
    output logic                         fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0]   fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0]   fbuf_data,
    output logic                         fbuf_rst_req_n
);

    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
    localparam int CNT_W = $clog2(CMD_FIFO_DEPTH) + 1;
    localparam int CMD_W = 64 + FBUF_DATA_WIDTH;
    localparam logic [CNT_W-1:0]           FIFO_FULL_CNT = CNT_W'(CMD_FIFO_DEPTH);
    localparam logic [16:0]                H_END         = 17'(H_RES);
    localparam logic [16:0]                V_END         = 17'(V_RES);
    localparam logic [FBUF_ADDR_WIDTH-1:0] ROW_STEP      = FBUF_ADDR_WIDTH'(H_RES);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FILL} state_t;

    wire clk   = s_axi_ctrl_aclk;
    wire rst_n = s_axi_ctrl_aresetn;

    // AXI channel state
    logic                      r_ready_en;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;
    logic                      r_aw_full;
    logic [2:0]                r_aw_idx;
    logic                      r_w_full;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;

    // Programming registers and flags
    logic [AXI_DATA_WIDTH-1:0] r_pos;
    logic [AXI_DATA_WIDTH-1:0] r_size;
    logic [AXI_DATA_WIDTH-1:0] r_color;
    logic                      r_ovf;
    logic                      r_clear_n;

    // Command FIFO
    logic [CMD_W-1:0] r_fifo_mem [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Engine
    state_t                     r_state;
    state_t                     w_next;
    logic [16:0]                r_x0, r_x, r_x_end, r_y, r_y_end;
    logic [FBUF_ADDR_WIDTH-1:0] r_row_base, r_addr;
    logic [FBUF_DATA_WIDTH-1:0] r_pix;

    logic                      w_arready, w_awready, w_wready;
    logic                      w_busy, w_full, w_empty;
    logic [7:0]                w_level;
    logic [AXI_DATA_WIDTH-1:0] w_status, w_rd_data;
    logic [1:0]                w_rd_resp;
    logic                      w_do_write, w_launch, w_push, w_pop, w_abort, w_clear, w_wr_err;
    logic [CMD_W-1:0]          w_head;
    logic [16:0]               w_hx0, w_hy0, w_hx_sum, w_hy_sum, w_hx_end, w_hy_end;
    logic                      w_cmd_ok;
    logic [FBUF_ADDR_WIDTH-1:0] w_hbase;
    logic                      w_row_last, w_last;
    logic                      w_unused;

    assign w_unused = ^{s_axi_ctrl_araddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_araddr[1:0],
                        s_axi_ctrl_awaddr[AXI_ADDRESS_WIDTH-1:5], s_axi_ctrl_awaddr[1:0]};

    // Ready signals stay low during reset and rise on the first edge after release.
    assign w_arready = r_ready_en & ~r_rvalid;
    assign w_awready = r_ready_en & ~r_aw_full & ~r_bvalid;
    assign w_wready  = r_ready_en & ~r_w_full & ~r_bvalid;

    assign s_axi_ctrl_arready = w_arready;
    assign s_axi_ctrl_awready = w_awready;
    assign s_axi_ctrl_wready  = w_wready;
    assign s_axi_ctrl_rvalid  = r_rvalid;
    assign s_axi_ctrl_rdata   = r_rdata;
    assign s_axi_ctrl_rresp   = r_rresp;
    assign s_axi_ctrl_bvalid  = r_bvalid;
    assign s_axi_ctrl_bresp   = r_bresp;
    assign fbuf_rst_req_n     = r_clear_n;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_full   = (r_count == FIFO_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_level  = 8'(r_count);
    assign w_status = {{(AXI_DATA_WIDTH-16){1'b0}}, w_level, 4'd0, r_ovf, w_empty, w_full, w_busy};

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = 2'b00;
        case (s_axi_ctrl_araddr[4:2])
            3'd0:    w_rd_data = w_status;
            3'd1:    w_rd_data = r_pos;
            3'd2:    w_rd_data = r_size;
            3'd3:    w_rd_data = r_color;
            3'd4:    w_rd_data = '0;
            default: w_rd_resp = 2'b10;
        endcase
    end

    // A register write fires once both the address and the data holding regs are loaded.
    assign w_do_write = r_aw_full & r_w_full;
    assign w_launch   = w_do_write && (r_aw_idx == 3'd4);
    assign w_push     = w_launch && !w_full;
    assign w_abort    = w_do_write && (r_aw_idx == 3'd0) && r_wdata[0];
    assign w_clear    = w_do_write && (r_aw_idx == 3'd0) && r_wdata[1];
    assign w_wr_err   = (r_aw_idx > 3'd4) || (w_launch && w_full);
    assign w_pop      = (r_state == ST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
        end else begin
            r_ready_en <= 1'b1;
            if (s_axi_ctrl_arvalid && w_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (r_rvalid && s_axi_ctrl_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= 3'd0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_pos     <= '0;
            r_size    <= '0;
            r_color   <= '0;
            r_ovf     <= 1'b0;
            r_clear_n <= 1'b1;
        end else begin
            r_clear_n <= ~w_clear;
            if (s_axi_ctrl_awvalid && w_awready) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= s_axi_ctrl_awaddr[4:2];
            end
            if (s_axi_ctrl_wvalid && w_wready) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_axi_ctrl_wdata;
            end
            if (r_bvalid && s_axi_ctrl_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_do_write) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_err ? 2'b10 : 2'b00;
                case (r_aw_idx)
                    3'd1:    r_pos   <= r_wdata;
                    3'd2:    r_size  <= r_wdata;
                    3'd3:    r_color <= r_wdata;
                    default: ;
                endcase
            end
            if (w_abort) begin
                r_ovf <= 1'b0;
            end else if (w_launch && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Queue storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {r_color[FBUF_DATA_WIDTH-1:0], r_size[31:0], r_pos[31:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Head-of-queue decode and clipping, consumed in LOAD.
    assign w_head   = r_fifo_mem[r_rd_ptr];
    assign w_hx0    = {1'b0, w_head[15:0]};
    assign w_hy0    = {1'b0, w_head[31:16]};
    assign w_hx_sum = w_hx0 + {1'b0, w_head[47:32]};
    assign w_hy_sum = w_hy0 + {1'b0, w_head[63:48]};
    assign w_hx_end = (w_hx_sum > H_END) ? H_END : w_hx_sum;
    assign w_hy_end = (w_hy_sum > V_END) ? V_END : w_hy_sum;
    assign w_cmd_ok = (w_hx0 < H_END) && (w_hy0 < V_END) &&
                      (w_head[47:32] != 16'd0) && (w_head[63:48] != 16'd0);
    assign w_hbase  = FBUF_ADDR_WIDTH'(32'(w_hy0) * 32'(H_RES) + 32'(w_hx0));

    assign w_row_last = ((r_x + 17'd1) == r_x_end);
    assign w_last     = w_row_last && ((r_y + 17'd1) == r_y_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (!w_empty) w_next = ST_LOAD;
            ST_LOAD: w_next = w_cmd_ok ? ST_FILL : ST_IDLE;
            ST_FILL: if (w_last) w_next = w_empty ? ST_IDLE : ST_LOAD;
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) w_next = ST_IDLE;
    end

    // Address/data are gated so the port reads zero whenever no pixel is written.
    always_comb begin
        fbuf_en_wr = (r_state == ST_FILL);
        fbuf_wrea  = (r_state == ST_FILL);
        fbuf_addr  = (r_state == ST_FILL) ? r_addr : '0;
        fbuf_data  = (r_state == ST_FILL) ? r_pix  : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0       <= '0;
            r_x        <= '0;
            r_x_end    <= '0;
            r_y        <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_pix      <= '0;
        end else if (r_state == ST_LOAD) begin
            r_x0       <= w_hx0;
            r_x        <= w_hx0;
            r_x_end    <= w_hx_end;
            r_y        <= w_hy0;
            r_y_end    <= w_hy_end;
            r_row_base <= w_hbase;
            r_addr     <= w_hbase;
            r_pix      <= w_head[CMD_W-1:64];
        end else if (r_state == ST_FILL) begin
            if (w_row_last) begin
                r_x        <= r_x0;
                r_y        <= r_y + 17'd1;
                r_row_base <= r_row_base + ROW_STEP;
                r_addr     <= r_row_base + ROW_STEP;
            end else begin
                r_x    <= r_x + 17'd1;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_rect_fill.sv
// Directed bench for axi4_lite_rect_fill: register access, fills with clipping,
// queue overflow, abort, clear pulse and asynchronous reset.
module tb_axi4_lite_rect_fill;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic        fbuf_en_wr;
    logic        fbuf_wrea;
    logic [18:0] fbuf_addr;
    logic [7:0]  fbuf_data;
    logic        fbuf_rst_req_n;

    int   checks = 0;
    int   errors = 0;
    logic en_before_b;
    logic en_at_b;

    always #5 clk = ~clk;

    axi4_lite_rect_fill dut (
        .s_axi_ctrl_aclk    (clk),
        .s_axi_ctrl_aresetn (rst_n),
        .s_axi_ctrl_araddr  (araddr),
        .s_axi_ctrl_arvalid (arvalid),
        .s_axi_ctrl_arready (arready),
        .s_axi_ctrl_rdata   (rdata),
        .s_axi_ctrl_rresp   (rresp),
        .s_axi_ctrl_rvalid  (rvalid),
        .s_axi_ctrl_rready  (rready),
        .s_axi_ctrl_awaddr  (awaddr),
        .s_axi_ctrl_awvalid (awvalid),
        .s_axi_ctrl_awready (awready),
        .s_axi_ctrl_wdata   (wdata),
        .s_axi_ctrl_wvalid  (wvalid),
        .s_axi_ctrl_wready  (wready),
        .s_axi_ctrl_bresp   (bresp),
        .s_axi_ctrl_bvalid  (bvalid),
        .s_axi_ctrl_bready  (bready),
        .fbuf_en_wr         (fbuf_en_wr),
        .fbuf_wrea          (fbuf_wrea),
        .fbuf_addr          (fbuf_addr),
        .fbuf_data          (fbuf_data),
        .fbuf_rst_req_n     (fbuf_rst_req_n)
    );

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int   n;
        logic aw_hs, w_hs;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1'b1; wdata = data; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 100) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        en_at_b = fbuf_en_wr;
        en_before_b = fbuf_en_wr;
        while (!bvalid && n < 100) begin
            en_before_b = en_at_b;
            @(posedge clk); #1;
            en_at_b = fbuf_en_wr;
            n++;
        end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h got no bvalid", addr);
            awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
        end else begin
            resp = bresp;
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
        while (!rvalid && n < 100) begin @(posedge clk); #1; n++; end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%h got no rvalid", addr);
            data = 'x; resp = 2'bxx;
        end else begin
            data = rdata; resp = rresp;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #50;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid, fbuf_en_wr, fbuf_wrea} !== 7'b0 ||
            fbuf_rst_req_n !== 1'b1 || fbuf_addr !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b%b%b rv=%b bv=%b en=%b rst_req_n=%b expected all 0, rst_req_n=1",
                     arready, awready, wready, rvalid, bvalid, fbuf_en_wr, fbuf_rst_req_n);
        end
        #50;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({arready, awready, wready} !== 3'b111 || {rvalid, bvalid} !== 2'b00) begin
            errors++;
            $display("FAIL ready_after_release got ar/aw/w=%b%b%b expected 111", arready, awready, wready);
        end
    endtask

    task automatic test_read_basic();
        logic [31:0] d, d0;
        logic [1:0]  r;
        logic        stable;
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h4 || r !== 2'b00) begin
            errors++; $display("FAIL status_after_reset got %h/%b expected 00000004/00", d, r);
        end
        axi_read(32'h1C, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL read_bad_offset got %h/%b expected 00000000/10", d, r);
        end
        axi_read(32'h10, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b00) begin
            errors++; $display("FAIL read_launch got %h/%b expected 00000000/00", d, r);
        end
        axi_write(32'h14, 32'h1234, r);
        checks++;
        if (r !== 2'b10) begin
            errors++; $display("FAIL write_bad_offset bresp got %b expected 10", r);
        end
        // rready held low: response must stay put
        @(posedge clk); #1;
        araddr = 32'h0; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        d0 = rdata;
        stable = (rvalid === 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable || d0 !== 32'h4) begin
            errors++; $display("FAIL read_hold got stable=%b rdata=%h expected stable=1 rdata=00000004", stable, d0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL read_release got rvalid=%b arready=%b expected 0/1", rvalid, arready);
        end
    endtask

    task automatic test_fill_small();
        logic [1:0]  r;
        logic [31:0] d;
        int exp_addr [6] = '{642, 643, 644, 1282, 1283, 1284};
        axi_write(32'h04, 32'h0001_0002, r);
        axi_write(32'h08, 32'h0002_0003, r);
        axi_write(32'h0C, 32'h0000_00E3, r);
        axi_read(32'h04, d, r);
        checks++;
        if (d !== 32'h0001_0002) begin
            errors++; $display("FAIL pos_readback got %h expected 00010002", d);
        end
        axi_write(32'h10, 32'hDEAD_BEEF, r);
        checks++;
        if (r !== 2'b00) begin
            errors++; $display("FAIL small_launch_bresp got %b expected 00", r);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= 1 && i <= 6) begin
                if (fbuf_en_wr !== 1'b1 || fbuf_wrea !== 1'b1 ||
                    fbuf_addr !== 19'(exp_addr[i-1]) || fbuf_data !== 8'hE3) begin
                    errors++;
                    $display("FAIL small_pixel%0d got en=%b addr=%0d data=%h expected en=1 addr=%0d data=e3",
                             i, fbuf_en_wr, fbuf_addr, fbuf_data, exp_addr[i-1]);
                end
            end else if (fbuf_en_wr !== 1'b0) begin
                errors++; $display("FAIL small_idle%0d got en=%b expected 0", i, fbuf_en_wr);
            end
            @(posedge clk); #1;
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h4) begin
            errors++; $display("FAIL small_status_done got %h expected 00000004", d);
        end
    endtask

    task automatic test_clip();
        logic [1:0]  r;
        logic [31:0] d;
        int          writes;
        axi_write(32'h04, 32'h01DF_027E, r);
        axi_write(32'h08, 32'h0005_0005, r);
        axi_write(32'h0C, 32'h0000_005A, r);
        axi_write(32'h10, 32'h0, r);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i == 1 || i == 2) begin
                if (fbuf_en_wr !== 1'b1 || fbuf_addr !== 19'(307197 + i) || fbuf_data !== 8'h5A) begin
                    errors++;
                    $display("FAIL clip_pixel%0d got en=%b addr=%0d data=%h expected en=1 addr=%0d data=5a",
                             i, fbuf_en_wr, fbuf_addr, fbuf_data, 307197 + i);
                end
            end else if (fbuf_en_wr !== 1'b0) begin
                errors++; $display("FAIL clip_idle%0d got en=%b expected 0", i, fbuf_en_wr);
            end
            @(posedge clk); #1;
        end
        axi_write(32'h08, 32'h0005_0000, r);
        axi_write(32'h10, 32'h0, r);
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            if (fbuf_en_wr === 1'b1) writes++;
            @(posedge clk); #1;
        end
        checks++;
        if (writes != 0) begin
            errors++; $display("FAIL zero_width_writes got %0d expected 0", writes);
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h4) begin
            errors++; $display("FAIL zero_width_status got %h expected 00000004", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  r;
        logic [1:0]  resps [6];
        logic [31:0] st_mid, d;
        int pix = 0, gaps = 0, addr_err = 0, data_err = 0;
        axi_write(32'h04, 32'h0, r);
        axi_write(32'h08, 32'h0064_0064, r);
        axi_write(32'h0C, 32'h77, r);
        fork
            begin
                for (int i = 0; i < 6; i++) axi_write(32'h10, 32'h0, resps[i]);
                axi_read(32'h00, st_mid, r);
                axi_write(32'h0C, 32'h11, r);
            end
            begin
                int n = 0, idle_run = 0, budget = 0, j;
                while (fbuf_en_wr !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
                while (pix < 50000 && idle_run < 20 && budget < 60000) begin
                    if (fbuf_en_wr === 1'b1) begin
                        j = pix % 10000;
                        if (fbuf_addr !== 19'((j / 100) * 640 + (j % 100))) addr_err++;
                        if (fbuf_data !== 8'h77) data_err++;
                        pix++;
                        idle_run = 0;
                    end else begin
                        gaps++;
                        idle_run++;
                    end
                    budget++;
                    @(posedge clk); #1;
                end
            end
        join
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (resps[i] !== ((i == 5) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL b2b_bresp%0d got %b expected %b", i, resps[i], (i == 5) ? 2'b10 : 2'b00);
            end
        end
        checks++;
        if (st_mid !== 32'h0000_040B) begin
            errors++; $display("FAIL b2b_status_full got %h expected 0000040b", st_mid);
        end
        checks++;
        if (pix != 50000 || gaps != 4) begin
            errors++; $display("FAIL b2b_pixels got pixels=%0d gaps=%0d expected 50000/4", pix, gaps);
        end
        checks++;
        if (addr_err != 0 || data_err != 0) begin
            errors++; $display("FAIL b2b_content got addr_err=%0d data_err=%0d expected 0/0", addr_err, data_err);
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h0000_000C) begin
            errors++; $display("FAIL b2b_status_ovf got %h expected 0000000c", d);
        end
    endtask

    task automatic test_abort();
        logic [1:0]  r;
        logic [31:0] d;
        int n = 0, writes = 0;
        axi_write(32'h08, 32'h0064_0064, r);
        axi_write(32'h10, 32'h0, r);
        while (fbuf_en_wr !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        repeat (20) begin @(posedge clk); #1; end
        axi_write(32'h00, 32'h1, r);
        checks++;
        if (en_before_b !== 1'b1 || en_at_b !== 1'b0 || r !== 2'b00) begin
            errors++; $display("FAIL abort_stop got en_before=%b en_after=%b bresp=%b expected 1/0/00",
                               en_before_b, en_at_b, r);
        end
        for (int i = 0; i < 20; i++) begin
            if (fbuf_en_wr === 1'b1) writes++;
            @(posedge clk); #1;
        end
        checks++;
        if (writes != 0) begin
            errors++; $display("FAIL abort_no_pixels got %0d expected 0", writes);
        end
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h4) begin
            errors++; $display("FAIL abort_status got %h expected 00000004", d);
        end
    endtask

    task automatic test_clear();
        logic [1:0] r;
        int lows = 0;
        fork
            axi_write(32'h00, 32'h2, r);
            for (int i = 0; i < 12; i++) begin
                if (fbuf_rst_req_n === 1'b0) lows++;
                @(posedge clk); #1;
            end
        join
        checks++;
        if (lows != 1 || r !== 2'b00) begin
            errors++; $display("FAIL clear_pulse got low_cycles=%0d bresp=%b expected 1/00", lows, r);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0]  r;
        logic [31:0] d;
        int n = 0, writes = 0;
        axi_write(32'h10, 32'h0, r);
        axi_write(32'h10, 32'h0, r);
        while (fbuf_en_wr !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (fbuf_en_wr !== 1'b1) begin
            errors++; $display("FAIL areset_prefill got en=%b expected 1", fbuf_en_wr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fbuf_en_wr !== 1'b0 || fbuf_addr !== 19'd0 || arready !== 1'b0 ||
            awready !== 1'b0 || fbuf_rst_req_n !== 1'b1) begin
            errors++; $display("FAIL areset_immediate got en=%b addr=%0d arready=%b awready=%b expected 0/0/0/0",
                               fbuf_en_wr, fbuf_addr, arready, awready);
        end
        #22;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            if (fbuf_en_wr === 1'b1) writes++;
            @(posedge clk); #1;
        end
        axi_read(32'h00, d, r);
        checks++;
        if (writes != 0 || d !== 32'h4) begin
            errors++; $display("FAIL areset_cleared got writes=%0d status=%h expected 0/00000004", writes, d);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_fill_small();
        test_clip();
        test_back_to_back();
        test_abort();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
